// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with registered result, high half and N/Z/C/V flags.
// Define ALU_MULDIV_EN for iterative MULU/DIVU behind start/busy/done.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       fun,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] RHI,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V
);
  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] sRes;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   sh;
  logic             sC;
  logic             sV;

  logic             wrEn;
  logic [WIDTH-1:0] wrRes;
  logic [WIDTH-1:0] wrHi;
  logic             wrC;
  logic             wrV;

  assign sh   = B[SHW-1:0];
  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} - {1'b0, B};

  always_comb begin
    sRes = '0;
    sC   = 1'b0;
    sV   = 1'b0;
    case (fun)
      4'd0: begin
        sRes = sum[WIDTH-1:0];
        sC   = sum[WIDTH];
        sV   = (A[WIDTH-1] == B[WIDTH-1]) &&
               (sum[WIDTH-1] != A[WIDTH-1]);
      end
      4'd1: begin
        sRes = diff[WIDTH-1:0];
        sC   = ~diff[WIDTH];
        sV   = (A[WIDTH-1] != B[WIDTH-1]) &&
               (diff[WIDTH-1] != A[WIDTH-1]);
      end
      4'd2: sRes = A & B;
      4'd3: sRes = A | B;
      4'd4: sRes = ~(A | B);
      4'd5: sRes = A << sh;
      4'd6: sRes = A >> sh;
      4'd7: sRes = WIDTH'($signed(A) >>> sh);
      default: sRes = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  state_t           stateNext;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opB;
  logic             opDiv;
  logic             isMulDiv;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic [WIDTH-1:0] divDiff;
  logic [WIDTH-1:0] stepHi;
  logic [WIDTH-1:0] stepLo;

  assign isMulDiv = (fun == 4'd8) || (fun == 4'd9);
  assign busy     = (state == RUN);

  // {hi,lo} is the product shift pair for MULU, remainder/quotient for DIVU
  always_comb begin
    mulSum   = {1'b0, hi} + {1'b0, opB & {WIDTH{lo[0]}}};
    divShift = {hi, lo[WIDTH-1]};
    divDiff  = divShift[WIDTH-1:0] - opB;
    stepHi   = mulSum[WIDTH:1];
    stepLo   = {mulSum[0], lo[WIDTH-1:1]};
    if (opDiv) begin
      if (divShift >= {1'b0, opB}) begin
        stepHi = divDiff;
        stepLo = {lo[WIDTH-2:0], 1'b1};
      end else begin
        stepHi = divShift[WIDTH-1:0];
        stepLo = {lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    stateNext = state;
    wrEn      = 1'b0;
    wrRes     = sRes;
    wrHi      = '0;
    wrC       = sC;
    wrV       = sV;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (isMulDiv) stateNext = RUN;
          else          wrEn      = 1'b1;
        end
      end
      RUN: begin
        if (cnt == CW'(1)) begin
          stateNext = IDLE;
          wrEn      = 1'b1;
          wrRes     = stepLo;
          wrHi      = stepHi;
          wrC       = !opDiv && (stepHi != '0);
          wrV       = opDiv && (opB == '0);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      opB   <= '0;
      opDiv <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == IDLE && start && isMulDiv) begin
        hi    <= '0;
        lo    <= A;
        opB   <= B;
        opDiv <= fun[0];
        cnt   <= CW'(WIDTH);
      end else if (state == RUN) begin
        hi  <= stepHi;
        lo  <= stepLo;
        cnt <= cnt - CW'(1);
      end
    end
  end
`else
  assign busy  = 1'b0;
  assign wrEn  = start;
  assign wrRes = sRes;
  assign wrHi  = '0;
  assign wrC   = sC;
  assign wrV   = sV;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
      R    <= '0;
      RHI  <= '0;
      N    <= 1'b0;
      Z    <= 1'b0;
      C    <= 1'b0;
      V    <= 1'b0;
    end else begin
      done <= wrEn;
      if (wrEn) begin
        R   <= wrRes;
        RHI <= wrHi;
        N   <= wrRes[WIDTH-1];
        Z   <= (wrRes == '0);
        C   <= wrC;
        V   <= wrV;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors against an arithmetic reference model
// plus hand-computed literal expectations.
module tb_alu_seq;
  localparam int W = 16;
`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   fun = '0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy, done;
  logic [W-1:0] R, RHI;
  logic         N, Z, C, V;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  bit armed = 1'b0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .fun(fun),
    .A(A), .B(B), .busy(busy), .done(done),
    .R(R), .RHI(RHI), .N(N), .Z(Z), .C(C), .V(V)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h want %h", nm, got, want);
  endtask

  function automatic void calc(input logic [3:0] f,
                               input logic [W-1:0] a, b,
                               output logic [W-1:0] r, rhi,
                               output logic c, v, output int lat);
    logic [2*W-1:0] p;
    int sh;
    r = '0; rhi = '0; c = 1'b0; v = 1'b0; lat = 0;
    sh = int'(b) % W;
    case (f)
      4'd0: begin
        {c, r} = {1'b0, a} + {1'b0, b};
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'd1: begin
        r = a - b;
        c = (a >= b);
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = ~(a | b);
      4'd5: r = a << sh;
      4'd6: r = a >> sh;
      4'd7: r = W'($signed(a) >>> sh);
      4'd8: if (MD) begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        r = p[W-1:0];
        rhi = p[2*W-1:W];
        c = (rhi != 0);
        lat = W;
      end
      4'd9: if (MD) begin
        if (b == 0) begin
          r = '1; rhi = a; v = 1'b1;
        end else begin
          r = a / b; rhi = a % b;
        end
        lat = W;
      end
      default: ;
    endcase
  endfunction

  logic [W-1:0] eR = '0, eRHI = '0, pR = '0, pRHI = '0;
  logic eN = 0, eZ = 0, eC = 0, eV = 0, pC = 0, pV = 0;
  logic eBusy = 0, eDone = 0;
  int remain = 0;
  int mlat;

  task automatic commit();
    eR = pR; eRHI = pRHI; eC = pC; eV = pV;
    eN = pR[W-1]; eZ = (pR == 0); eDone = 1'b1;
  endtask

  always @(posedge clk) begin
    cyc++;
    eDone = 1'b0;
    if (rst) begin
      eR = '0; eRHI = '0; eN = 0; eZ = 0; eC = 0; eV = 0; remain = 0;
    end else if (remain > 0) begin
      remain--;
      if (remain == 0) commit();
    end else if (start) begin
      calc(fun, A, B, pR, pRHI, pC, pV, mlat);
      if (mlat == 0) commit();
      else remain = mlat;
    end
    eBusy = (remain > 0);
  end

  always @(negedge clk)
    if (armed)
      check("cycle", {busy, done, R, RHI, N, Z, C, V},
            {eBusy, eDone, eR, eRHI, eN, eZ, eC, eV});

  task automatic op(input logic [3:0] f, input logic [W-1:0] a, b,
                    output int lat);
    int c0;
    fun = f; A = a; B = b; start = 1'b1; c0 = cyc;
    @(negedge clk);
    start = 1'b0; fun = 4'd1; A = W'($urandom); B = W'($urandom);
    for (int i = 0; i < W + 4 && !done; i++) begin
      if (i == 3) begin start = 1'b1; fun = 4'd0; end
      if (i == 4) start = 1'b0;
      @(negedge clk);
    end
    lat = cyc - c0 - 1;
    if (!done) begin
      total++;
      $display("FAIL op_timeout: done got 0 want 1 (fun %0d)", f);
    end
  endtask

  initial begin
    int lat;
    int dones;
    repeat (2) @(negedge clk);
    armed = 1'b1;
    check("reset", {busy, done, R, RHI, N, Z, C, V}, '0);
    rst = 1'b0;
    @(negedge clk);

    op(4'd0, 16'hFFFF, 16'h0001, lat);
    check("add_R", R, 16'h0000);
    check("add_ZCV", {Z, C, V}, 3'b110);
    check("add_lat", lat, 0);
    op(4'd0, 16'h7FFF, 16'h0001, lat);
    check("addovf_NZCV", {R, N, Z, C, V}, {16'h8000, 4'b1001});
    op(4'd1, 16'h8000, 16'h7FFF, lat);
    check("sub_R", R, 16'h0001);
    check("sub_NZCV", {N, Z, C, V}, 4'b0011);
    op(4'd7, 16'h8000, 16'h0001, lat);
    check("sar_R", {R, N}, {16'hC000, 1'b1});
    op(4'd2, 16'hF0F0, 16'hFF00, lat);
    check("and_R", R, 16'hF000);
    op(4'd3, 16'h0F0F, 16'h00F0, lat);
    check("or_R", R, 16'h0FFF);
    op(4'd4, 16'h0F0F, 16'hF0F0, lat);
    check("nor_RZ", {R, Z}, {16'h0000, 1'b1});
    op(4'd5, 16'h0001, 16'h0013, lat);
    check("shl_R", R, 16'h0008);
    op(4'd6, 16'h8000, 16'h000F, lat);
    check("shr_R", R, 16'h0001);
    op(4'd7, 16'h4000, 16'h0002, lat);
    check("sar_pos_R", R, 16'h1000);
    op(4'd12, 16'hFFFF, 16'hFFFF, lat);
    check("rsv_R", {R, RHI, N, Z, C, V}, {32'h0, 4'b0100});

`ifdef ALU_MULDIV_EN
    op(4'd8, 16'h0100, 16'h0100, lat);
    check("mulu_R", {R, RHI}, {16'h0000, 16'h0001});
    check("mulu_ZC", {Z, C}, 2'b11);
    check("mulu_lat", lat, 16);
    op(4'd9, 16'h0064, 16'h0007, lat);
    check("divu_R", {R, RHI, V}, {16'h000E, 16'h0002, 1'b0});
    op(4'd9, 16'h1234, 16'h0000, lat);
    check("div0_R", {R, RHI}, {16'hFFFF, 16'h1234});
    check("div0_NV", {N, V}, 2'b11);
    op(4'd8, 16'hFFFF, 16'hFFFF, lat);
    op(4'd9, 16'hFFFF, 16'h0003, lat);
    op(4'd0, 16'h1111, 16'h2222, lat);
    check("add_after_R", R, 16'h3333);
    fun = 4'd8; A = 16'h0003; B = 16'h0005; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort", {busy, done, R, RHI, N, Z, C, V}, '0);
    dones = 0;
    repeat (W + 4) begin
      @(negedge clk);
      dones += int'(done);
    end
    check("abort_nodone", dones, 0);
`else
    op(4'd8, 16'h0003, 16'h0004, lat);
    check("mulu_off", {R, RHI, Z, busy}, {32'h0, 2'b10});
    check("mulu_off_lat", lat, 0);
    op(4'd9, 16'h0064, 16'h0007, lat);
    check("divu_off", {R, RHI, Z}, {32'h0, 1'b1});
    op(4'd0, 16'h0003, 16'h0004, lat);
    check("add_off_R", R, 16'h0007);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid", {busy, done, R, RHI, N, Z, C, V}, '0);
    @(negedge clk);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
